// File: rtl/seq_mult_sequencer.sv
// seq_mult_sequencer: signed shift-add multiplier controller with start/busy/done handshake
module seq_mult_sequencer #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic                       busy,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   result,
  output logic                       sign
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_ADD, SIGN_FIX, DONE} state_t;
  state_t state, next;
  logic [W-1:0]   a_q, b_q, mag_a, mag_b;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic           sign_int;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = start ? LOAD : IDLE;
      LOAD:      next = SHIFT_ADD;
      SHIFT_ADD: next = (cnt == CW'(W-1)) ? SIGN_FIX : SHIFT_ADD;
      SIGN_FIX:  next = DONE;
      default:   next = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == LOAD) || (state == SHIFT_ADD) || (state == SIGN_FIX);
    done = (state == DONE);
  end
  // Magnitudes are W-bit unsigned, so |-2^(W-1)| = 2^(W-1) is exact.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_int <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q <= multiplicand;
          b_q <= multiplier;
        end
        LOAD: begin
          mag_a    <= a_q[W-1] ? -a_q : a_q;
          mag_b    <= b_q[W-1] ? -b_q : b_q;
          sign_int <= a_q[W-1] ^ b_q[W-1];
          acc      <= '0;
          cnt      <= '0;
        end
        SHIFT_ADD: begin
          if (mag_b[cnt]) acc <= acc + ({{W{1'b0}}, mag_a} << cnt);
          cnt <= cnt + 1'b1;
        end
        SIGN_FIX: begin
          result <= (acc == '0) ? '0 : (sign_int ? -acc : acc);
          sign   <= sign_int && (acc != '0);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_seq_mult_sequencer.sv
// tb_seq_mult_sequencer: vector table plus scoreboard bench for the W=8 multiplier sequencer
module tb_seq_mult_sequencer;
  localparam int W = 8;
  logic clk = 0, reset = 1, start = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, sign;
  logic [2*W-1:0] result;
  typedef struct {logic [15:0] r; logic s;} exp_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] r; logic s;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t vt[9];
  int checks = 0, errors = 0;

  seq_mult_sequencer #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .multiplicand(a), .multiplier(b),
    .busy(busy), .done(done), .result(result), .sign(sign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("sign", sign, e.s);
      end
    end

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] r, input logic s);
    int n, nb;
    @(negedge clk);
    a = va; b = vb; start = 1;
    sb.push_back('{r, s});
    @(posedge clk);
    #1 start = 0;
    a = ~va; b = ~vb;
    n = 0;
    nb = busy ? 1 : 0;
    while (n < 40 && !done) begin
      @(posedge clk);
      #1 n++;
      if (busy) nb++;
    end
    chk("latency", n, 10);
    chk("busy_cycles", nb, 10);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [15:0] p;
    vt[0] = '{8'd7,    8'hFD, 16'hFFEB, 1'b1};
    vt[1] = '{8'h80,   8'h80, 16'h4000, 1'b0};
    vt[2] = '{8'd0,    8'hFB, 16'h0000, 1'b0};
    vt[3] = '{8'hFF,   8'd127, 16'hFF81, 1'b1};
    vt[4] = '{8'h80,   8'd127, 16'hC080, 1'b1};
    vt[5] = '{8'd127,  8'h80, 16'hC080, 1'b1};
    vt[6] = '{8'h80,   8'd1,  16'hFF80, 1'b1};
    vt[7] = '{8'hFB,   8'd0,  16'h0000, 1'b0};
    vt[8] = '{8'd127,  8'd127, 16'h3F01, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_sign", sign, 0);
    reset = 0;
    for (int i = 0; i < 9; i++) run_op(vt[i].a, vt[i].b, vt[i].r, vt[i].s);
    // start held high with operands changing every cycle
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); start = 1;
      if (i % 12 == 0) begin
        p = $signed(a) * $signed(b);
        sb.push_back('{p, p[15]});
      end
      @(posedge clk);
      #1 chk("period_done", done, (i % 12) == 10);
    end
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #1;
    // abort in the 4th SHIFT_ADD cycle
    @(negedge clk);
    a = 8'd5; b = 8'd6; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_sign", sign, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    run_op(8'd5, 8'd6, 16'h001E, 1'b0);
    run_op(8'd3, 8'd4, 16'h000C, 1'b0);
    repeat (20) begin
      @(negedge clk);
      chk("hold_result", result, 16'h000C);
      chk("hold_done", done, 0);
      chk("hold_busy", busy, 0);
    end
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
